// File: rtl/rs_decode_sequencer.sv
// rs_decode_sequencer: symbol-serial single-error Reed-Solomon decoder for
// RS(N, N-2), t = 1.
//
// A codeword is accepted on an in_valid/in_ready handshake. The block then
// computes S1/S2 by Horner iteration (N cycles) and solves X1 = S2/S1 and
// Y1 = S1^2/S2 (1 cycle). It scans positions for X1 == alpha^idx and patches
// the matching symbol (N cycles, fixed latency). The result is held on
// corrected with one status flag until out_valid/out_ready.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   in_valid / in_ready   input handshake; codeword sampled on accept only
//   codeword  [N*W]       symbol i at [i*W +: W] is the coefficient of x^i
//   out_valid / out_ready output handshake
//   corrected [N*W]       decoded codeword
//   err_none/err_corrected/err_fail  one-hot status, 0 while out_valid = 0

`ifndef N
`define N 15
`endif
`ifndef SYMBOL_WIDTH
`define SYMBOL_WIDTH 4
`endif

module rs_decode_sequencer #(
  parameter int N    = `N,
  parameter int W    = `SYMBOL_WIDTH,
  // Primitive field polynomial, including the x^W term.
  parameter int POLY = (W == 3) ? 'hB  :
                       (W == 4) ? 'h13 :
                       (W == 5) ? 'h25 :
                       (W == 6) ? 'h43 :
                       (W == 7) ? 'h89 : 'h11D
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] codeword,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*W-1:0] corrected,
  output logic           err_none,
  output logic           err_corrected,
  output logic           err_fail
);

  localparam int IW = (N > 2) ? $clog2(N) : 1;
  localparam logic [W-1:0] RED    = POLY[W-1:0];
  localparam logic [W-1:0] ALPHA  = W'(2);
  localparam logic [W-1:0] ALPHA2 = W'(4);
  localparam logic [W-1:0] ONE    = W'(1);

  typedef enum logic [2:0] {S_IDLE, S_SYND, S_SOLVE, S_LOCATE, S_DONE} state_t;
  typedef enum logic [1:0] {C_NONE, C_FAIL, C_PEND} cls_t;

  // Shift-and-add GF(2^W) multiplier; with a constant operand it reduces
  // to a small XOR network.
  function automatic logic [W-1:0] gf_mul(input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic [W-1:0] r;
    logic [W-1:0] x;
    r = '0;
    x = a;
    for (int i = 0; i < W; i++) begin
      if (b[i]) r = r ^ x;
      x = x[W-1] ? ((x << 1) ^ RED) : (x << 1);
    end
    return r;
  endfunction

  // Inverse by Fermat: a^(2^W - 2) = prod_{k=1..W-1} a^(2^k).
  function automatic logic [W-1:0] gf_inv(input logic [W-1:0] a);
    logic [W-1:0] sq;
    logic [W-1:0] r;
    sq = a;
    r  = ONE;
    for (int k = 1; k < W; k++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [W-1:0] gf_div(input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    return gf_mul(a, gf_inv(b));
  endfunction

  state_t               state_q;
  cls_t                 cls_q;
  logic [N-1:0][W-1:0]  buf_q;
  logic [W-1:0]         s1_q, s2_q, x1_q, y1_q, p_q;
  logic [IW-1:0]        idx_q;
  logic                 hit_q;
  logic                 in_ready_q, out_valid_q;
  logic                 none_q, corr_q, fail_q;

  logic [W-1:0] x1_c, y1_c;
  logic         loc_hit;

  assign x1_c    = gf_div(s2_q, s1_q);
  assign y1_c    = gf_div(gf_mul(s1_q, s1_q), s2_q);
  // X1 is a power of alpha and alpha^idx is distinct over the scan, so at
  // most one position can match; hit_q guards it anyway.
  assign loc_hit = (cls_q == C_PEND) && !hit_q && (p_q == x1_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cls_q       <= C_NONE;
      buf_q       <= '0;
      s1_q        <= '0;
      s2_q        <= '0;
      x1_q        <= '0;
      y1_q        <= '0;
      p_q         <= '0;
      idx_q       <= '0;
      hit_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      none_q      <= 1'b0;
      corr_q      <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // in_ready rises one cycle after reset release.
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            buf_q      <= codeword;
            s1_q       <= '0;
            s2_q       <= '0;
            idx_q      <= IW'(N - 1);
            in_ready_q <= 1'b0;
            state_q    <= S_SYND;
          end
        end
        S_SYND: begin
          // Horner from the highest-order symbol down.
          s1_q  <= gf_mul(s1_q, ALPHA)  ^ buf_q[idx_q];
          s2_q  <= gf_mul(s2_q, ALPHA2) ^ buf_q[idx_q];
          idx_q <= idx_q - IW'(1);
          if (idx_q == '0) state_q <= S_SOLVE;
        end
        S_SOLVE: begin
          if (s1_q == '0 && s2_q == '0) begin
            cls_q <= C_NONE;
            x1_q  <= '0;
            y1_q  <= '0;
          end else if (s1_q == '0 || s2_q == '0) begin
            cls_q <= C_FAIL;
            x1_q  <= '0;
            y1_q  <= '0;
          end else begin
            cls_q <= C_PEND;
            x1_q  <= x1_c;
            y1_q  <= y1_c;
          end
          p_q     <= ONE;
          idx_q   <= '0;
          hit_q   <= 1'b0;
          state_q <= S_LOCATE;
        end
        S_LOCATE: begin
          if (loc_hit) begin
            buf_q[idx_q] <= buf_q[idx_q] ^ y1_q;
            hit_q        <= 1'b1;
          end
          p_q   <= gf_mul(p_q, ALPHA);
          idx_q <= idx_q + IW'(1);
          if (idx_q == IW'(N - 1)) begin
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
            // A match on the final position counts toward the verdict.
            case (cls_q)
              C_NONE:  none_q <= 1'b1;
              C_FAIL:  fail_q <= 1'b1;
              default: begin
                if (hit_q || loc_hit) corr_q <= 1'b1;
                else                  fail_q <= 1'b1;
              end
            endcase
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            none_q      <= 1'b0;
            corr_q      <= 1'b0;
            fail_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign corrected     = buf_q;
  assign err_none      = none_q;
  assign err_corrected = corr_q;
  assign err_fail      = fail_q;

endmodule
